// File: rtl/uart_cfg.sv
// uart_cfg: runtime-configurable UART (divisor, parity, stop bits) with RX/TX FIFOs.
// Optional build macro UART_CFG_LOOPBACK_EN adds a loopback input feeding RX from TX.

module uart_cfg_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         rd_i,
  input  logic         wr_i,
  input  logic [W-1:0] w_data_i,
  output logic [W-1:0] r_data_o,
  output logic         empty_o,
  output logic         full_o
);
  logic [W-1:0]  mem_q [2**AW];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          wr_en, rd_en;
  assign empty_o  = cnt_q == '0;
  assign full_o   = cnt_q[AW];
  assign wr_en    = wr_i & (~full_o | rd_i);
  assign rd_en    = rd_i & ~empty_o;
  assign r_data_o = empty_o ? '0 : mem_q[rp_q];
  // storage needs no reset: the head output is masked while empty
  always_ff @(posedge clk)
    if (wr_en) mem_q[wp_q] <= w_data_i;
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wp_q <= wp_q + 1'b1;
      if (rd_en) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
endmodule

module uart_cfg #(
  parameter int DBIT     = 8,
  parameter int DVSR_BIT = 11,
  parameter int FIFO_W   = 2,
  parameter int OS       = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DVSR_BIT-1:0] dvsr,
  input  logic [1:0]          par_mode,
  input  logic                stop2,
  input  logic                rx,
  input  logic                rd_uart,
  input  logic                wr_uart,
  input  logic [DBIT-1:0]     w_data,
  input  logic                clr_err,
`ifdef UART_CFG_LOOPBACK_EN
  input  logic                loopback,
`endif
  output logic [DBIT-1:0]     r_data,
  output logic                r_perr,
  output logic                r_ferr,
  output logic                rx_empty,
  output logic                tx_full,
  output logic                tx,
  output logic                tx_busy,
  output logic                overrun
);
  localparam int SW = $clog2(3 * OS);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_HALF = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic [DVSR_BIT-1:0] cnt_q, cnt_d;
  logic                tick, rx_in, tx_q;
  logic                ovr_q, ovr_d, drop;
  state_t              rs_q, ts_q;
  logic [SW-1:0]       rsc_q, tsc_q, rx_end, tx_end;
  logic [NW-1:0]       rn_q, tn_q;
  logic [DBIT-1:0]     rb_q, tb_q, tx_head;
  logic                rpar_q, rodd_q, rst2_q, rperr_q, rferr_q, rx_push, rx_full;
  logic                tpar_q, tpbit_q, tst2_q, tx_pop, tx_empty, tx_stop_done;
  assign tick  = cnt_q == dvsr;
  assign cnt_d = (cnt_q >= dvsr) ? '0 : cnt_q + 1'b1;
  // baud tick generator; an out-of-range count after a divisor change wraps to 0
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`ifdef UART_CFG_LOOPBACK_EN
  assign rx_in = loopback ? tx_q : rx;
  assign tx    = loopback | tx_q;
`else
  assign rx_in = rx;
  assign tx    = tx_q;
`endif
  assign rx_end = rst2_q ? SW'(2 * OS + OS / 2 - 1) : SW'(OS + OS / 2 - 1);
  // RX engine: samples mid-bit, returns to IDLE just before the stop period ends
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rs_q    <= IDLE;
      rsc_q   <= '0;
      rn_q    <= '0;
      rb_q    <= '0;
      rpar_q  <= 1'b0;
      rodd_q  <= 1'b0;
      rst2_q  <= 1'b0;
      rperr_q <= 1'b0;
      rferr_q <= 1'b0;
      rx_push <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      case (rs_q)
        IDLE: if (!rx_in) begin
          rs_q  <= START;
          rsc_q <= '0;
        end
        START: if (tick) begin
          if (rsc_q == S_HALF) begin
            rsc_q   <= '0;
            rn_q    <= '0;
            rperr_q <= 1'b0;
            rferr_q <= 1'b0;
            rpar_q  <= par_mode[0] ^ par_mode[1];
            rodd_q  <= par_mode[1];
            rst2_q  <= stop2;
            rs_q    <= rx_in ? IDLE : DATA;
          end else rsc_q <= rsc_q + 1'b1;
        end
        DATA: if (tick) begin
          if (rsc_q == S_BIT) begin
            rsc_q <= '0;
            rb_q  <= {rx_in, rb_q[DBIT-1:1]};
            rn_q  <= rn_q + 1'b1;
            if (rn_q == N_LAST) rs_q <= rpar_q ? PARITY : STOP;
          end else rsc_q <= rsc_q + 1'b1;
        end
        PARITY: if (tick) begin
          if (rsc_q == S_BIT) begin
            rsc_q   <= '0;
            rperr_q <= rx_in ^ rodd_q ^ (^rb_q);
            rs_q    <= STOP;
          end else rsc_q <= rsc_q + 1'b1;
        end
        STOP: if (tick) begin
          if (rsc_q == S_BIT && !rx_in) rferr_q <= 1'b1;
          if (rsc_q == rx_end) begin
            rs_q    <= IDLE;
            rx_push <= 1'b1;
          end else rsc_q <= rsc_q + 1'b1;
        end
        default: rs_q <= IDLE;
      endcase
    end
  assign tx_end       = tst2_q ? SW'(2 * OS - 1) : SW'(OS - 1);
  assign tx_stop_done = ts_q == STOP && tick && tsc_q == tx_end;
  assign tx_pop       = (ts_q == IDLE || tx_stop_done) && !tx_empty;
  // TX engine: registered serial output, chains frames straight from STOP
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ts_q    <= IDLE;
      tx_q    <= 1'b1;
      tsc_q   <= '0;
      tn_q    <= '0;
      tb_q    <= '0;
      tpar_q  <= 1'b0;
      tpbit_q <= 1'b0;
      tst2_q  <= 1'b0;
    end else if (tx_pop) begin
      ts_q    <= START;
      tx_q    <= 1'b0;
      tsc_q   <= '0;
      tb_q    <= tx_head;
      tpar_q  <= par_mode[0] ^ par_mode[1];
      tpbit_q <= par_mode[1] ^ (^tx_head);
      tst2_q  <= stop2;
    end else begin
      case (ts_q)
        START: if (tick) begin
          if (tsc_q == S_BIT) begin
            tsc_q <= '0;
            tn_q  <= '0;
            ts_q  <= DATA;
            tx_q  <= tb_q[0];
          end else tsc_q <= tsc_q + 1'b1;
        end
        DATA: if (tick) begin
          if (tsc_q == S_BIT) begin
            tsc_q <= '0;
            tn_q  <= tn_q + 1'b1;
            tb_q  <= tb_q >> 1;
            if (tn_q == N_LAST) begin
              ts_q <= tpar_q ? PARITY : STOP;
              tx_q <= tpar_q ? tpbit_q : 1'b1;
            end else tx_q <= tb_q[1];
          end else tsc_q <= tsc_q + 1'b1;
        end
        PARITY: if (tick) begin
          if (tsc_q == S_BIT) begin
            tsc_q <= '0;
            ts_q  <= STOP;
            tx_q  <= 1'b1;
          end else tsc_q <= tsc_q + 1'b1;
        end
        STOP: if (tick) begin
          if (tsc_q == tx_end) ts_q <= IDLE;
          else tsc_q <= tsc_q + 1'b1;
        end
        default: tx_q <= 1'b1;
      endcase
    end
  assign tx_busy = ts_q != IDLE || !tx_empty;
  assign drop    = rx_push & rx_full & ~rd_uart;
  assign ovr_d   = drop | (ovr_q & ~clr_err);
  assign overrun = ovr_q;
  // sticky overrun: a coincident drop wins over clr_err
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ovr_q <= 1'b0;
    else ovr_q <= ovr_d;
  uart_cfg_fifo #(.W(DBIT + 2), .AW(FIFO_W)) u_rx_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_i     (rd_uart),
    .wr_i     (rx_push),
    .w_data_i ({rferr_q, rperr_q, rb_q}),
    .r_data_o ({r_ferr, r_perr, r_data}),
    .empty_o  (rx_empty),
    .full_o   (rx_full)
  );
  uart_cfg_fifo #(.W(DBIT), .AW(FIFO_W)) u_tx_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_i     (tx_pop),
    .wr_i     (wr_uart),
    .w_data_i (w_data),
    .r_data_o (tx_head),
    .empty_o  (tx_empty),
    .full_o   (tx_full)
  );
endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg: directed self-checking bench for uart_cfg at dvsr=3 (64 clocks per bit).
module tb_uart_cfg;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [10:0] dvsr = 11'd3;
  logic [1:0]  par_mode = 2'b00;
  logic        stop2 = 1'b0, rx = 1'b1, rd_uart = 1'b0, wr_uart = 1'b0, clr_err = 1'b0;
  logic [7:0]  w_data = 8'h00, r_data;
  logic        r_perr, r_ferr, rx_empty, tx_full, tx, tx_busy, overrun;
  int          checks = 0, failures = 0;

  uart_cfg dut (
    .clk(clk), .reset_n(reset_n), .dvsr(dvsr), .par_mode(par_mode), .stop2(stop2),
    .rx(rx), .rd_uart(rd_uart), .wr_uart(wr_uart), .w_data(w_data), .clr_err(clr_err),
    .r_data(r_data), .r_perr(r_perr), .r_ferr(r_ferr), .rx_empty(rx_empty),
    .tx_full(tx_full), .tx(tx), .tx_busy(tx_busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    w_data = d;
    wr_uart = 1'b1;
    @(posedge clk); #1;
    wr_uart = 1'b0;
  endtask

  task automatic pop_rx();
    rd_uart = 1'b1;
    @(posedge clk); #1;
    rd_uart = 1'b0;
  endtask

  task automatic rx_bit(input logic b);
    rx = b;
    repeat (64) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_en, input logic pbit, input logic sbit);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(d[i]);
    if (par_en) rx_bit(pbit);
    rx_bit(sbit);
    rx = 1'b1;
  endtask

  task automatic wait_rx(input string tag);
    int k = 0;
    while (rx_empty !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    chk({tag, "_ready"}, 32'(rx_empty), 32'd0);
  endtask

  task automatic check_tx_frame(input string tag, input logic [11:0] bits, input int nb);
    int k = 0;
    int t = 0;
    while (tx !== 1'b0 && k < 300) begin @(negedge clk); k++; end
    chk({tag, "_start_seen"}, 32'(k < 300), 32'd1);
    if (k >= 300) return;
    for (int i = 0; i < nb; i++) begin
      while (t < 64 * i + 30) begin @(negedge clk); t++; end
      chk($sformatf("%s_bit%0d", tag, i), 32'(tx), 32'(bits[i]));
    end
    chk({tag, "_busy_in_stop"}, 32'(tx_busy), 32'd1);
    while (t < 64 * nb + 30) begin @(negedge clk); t++; end
    chk({tag, "_busy_after"}, 32'(tx_busy), 32'd0);
    chk({tag, "_idle_high"}, 32'(tx), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("rst_rx_empty", 32'(rx_empty), 32'd1);
    chk("rst_tx_full", 32'(tx_full), 32'd0);
    chk("rst_r_data", 32'(r_data), 32'd0);
    chk("rst_r_perr", 32'(r_perr), 32'd0);
    chk("rst_r_ferr", 32'(r_ferr), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk); #1;

    par_mode = 2'b01;
    push_tx(8'hA5);
    check_tx_frame("tx_a5_even", 12'h54A, 11);

    par_mode = 2'b10;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    wait_rx("rx_3c");
    chk("rx_3c_data", 32'(r_data), 32'h3C);
    chk("rx_3c_perr", 32'(r_perr), 32'd1);
    chk("rx_3c_ferr", 32'(r_ferr), 32'd0);
    pop_rx();
    @(negedge clk);
    chk("rx_3c_popped", 32'(rx_empty), 32'd1);

    par_mode = 2'b00;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    wait_rx("rx_55");
    chk("rx_55_data", 32'(r_data), 32'h55);
    chk("rx_55_ferr", 32'(r_ferr), 32'd1);
    chk("rx_55_perr", 32'(r_perr), 32'd0);
    repeat (100) @(posedge clk); #1;
    pop_rx();
    @(negedge clk);
    chk("rx_55_popped", 32'(rx_empty), 32'd1);

    rx = 1'b0;
    repeat (16) @(posedge clk); #1;
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_no_write", 32'(rx_empty), 32'd1);

    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i * 8'h11), 1'b0, 1'b0, 1'b1);
      repeat (16) @(posedge clk); #1;
    end
    @(negedge clk);
    chk("ovr_four_ok", 32'(overrun), 32'd0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    chk("ovr_set", 32'(overrun), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("ovr_word%0d", i), 32'(r_data), 32'(i * 8'h11));
      #1;
      pop_rx();
    end
    @(negedge clk);
    chk("ovr_drained", 32'(rx_empty), 32'd1);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    @(posedge clk); #1;
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", 32'(overrun), 32'd0);

    par_mode = 2'b00;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) push_tx(8'h00);
    @(negedge clk);
    chk("txf_full", 32'(tx_full), 32'd1);
    repeat (100) @(negedge clk);
    chk("txf_midbit_low", 32'(tx), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_tx", 32'(tx), 32'd1);
    chk("arst_tx_full", 32'(tx_full), 32'd0);
    chk("arst_tx_busy", 32'(tx_busy), 32'd0);
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    par_mode = 2'b10;
    stop2 = 1'b1;
    push_tx(8'h81);
    check_tx_frame("tx_81_odd_2stop", 12'hF02, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
